// File: rtl/alu_ex_stage_pkg.sv
// Shared widths, ALU operation encodings and stage state type for the MIPS execute stage.
package alu_ex_stage_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_WIDTH  = 32;

  typedef enum logic [2:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_LUI  = 3'b011,
    ALU_SLTU = 3'b100,
    ALU_SLL  = 3'b101,
    ALU_SUB  = 3'b110,
    ALU_SLT  = 3'b111
  } alu_op_e;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Two's-complement overflow from the sign bits of the adder inputs and sum.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    add_ovf = (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/alu_ex_stage_if.sv
// Handshake, EX/MEM pipeline register and perf-counter bundle of the execute stage.
interface alu_ex_stage_if #(
  parameter int DATA_WIDTH = alu_ex_stage_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = alu_ex_stage_pkg::CNT_WIDTH
);
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_aluop;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  in_trap_en;
  logic                  in_wen;
  logic [4:0]            in_waddr;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_result;
  logic                  out_zero;
  logic                  out_carry;
  logic                  out_exc;
  logic                  out_wen;
  logic [4:0]            out_waddr;
  logic [CNT_WIDTH-1:0]  cnt_issued;
  logic [CNT_WIDTH-1:0]  cnt_stall;
  logic [CNT_WIDTH-1:0]  cnt_ovf;

  modport master (
    output in_valid, in_aluop, in_a, in_b, in_trap_en, in_wen, in_waddr, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_exc, out_wen, out_waddr,
    input  cnt_issued, cnt_stall, cnt_ovf
  );

  modport slave (
    input  in_valid, in_aluop, in_a, in_b, in_trap_en, in_wen, in_waddr, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_exc, out_wen, out_waddr,
    output cnt_issued, cnt_stall, cnt_ovf
  );
endinterface

// File: rtl/alu_ex_stage_alu.sv
// Combinational MIPS ALU: result, Zero, CarryOut and signed Overflow (ADD/SUB only).
module alu_ex_stage_alu #(
  parameter int DATA_WIDTH = alu_ex_stage_pkg::DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic [2:0]            aluop_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  zero_o,
  output logic                  carry_o,
  output logic                  ovf_o
);
  import alu_ex_stage_pkg::*;

  logic [DATA_WIDTH:0] sum_s;
  logic [DATA_WIDTH:0] diff_s;

  assign sum_s  = {1'b0, a_i} + {1'b0, b_i};
  // Subtract as a + ~b + 1 so CarryOut is the MIPS-style no-borrow flag.
  assign diff_s = {1'b0, a_i} + {1'b0, ~b_i} + {{DATA_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    result_o = {DATA_WIDTH{1'b0}};
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    case (alu_op_e'(aluop_i))
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_ADD: begin
        result_o = sum_s[DATA_WIDTH-1:0];
        carry_o  = sum_s[DATA_WIDTH];
        ovf_o    = add_ovf(a_i[DATA_WIDTH-1], b_i[DATA_WIDTH-1], sum_s[DATA_WIDTH-1]);
      end
      ALU_SUB: begin
        result_o = diff_s[DATA_WIDTH-1:0];
        carry_o  = diff_s[DATA_WIDTH];
        ovf_o    = add_ovf(a_i[DATA_WIDTH-1], ~b_i[DATA_WIDTH-1], diff_s[DATA_WIDTH-1]);
      end
      ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_LUI:  result_o = {b_i[DATA_WIDTH-17:0], 16'h0000};
      ALU_SLL:  result_o = b_i << a_i[4:0];
      default:  result_o = {DATA_WIDTH{1'b0}};
    endcase
  end

  assign zero_o = (result_o == {DATA_WIDTH{1'b0}});

endmodule

// File: rtl/alu_ex_stage.sv
// MIPS execute stage: valid/ready capture into the EX/MEM register, overflow traps, perf counters.
module alu_ex_stage #(
  parameter int DATA_WIDTH = alu_ex_stage_pkg::DATA_WIDTH,
  parameter int CNT_WIDTH  = alu_ex_stage_pkg::CNT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  alu_ex_stage_if.slave   bus
);
  import alu_ex_stage_pkg::*;

  stage_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic                  exc_q, exc_d;
  logic                  wen_q, wen_d;
  logic [4:0]            waddr_q, waddr_d;
  logic [CNT_WIDTH-1:0]  cnt_issued_q, cnt_issued_d;
  logic [CNT_WIDTH-1:0]  cnt_stall_q, cnt_stall_d;
  logic [CNT_WIDTH-1:0]  cnt_ovf_q, cnt_ovf_d;

  logic [DATA_WIDTH-1:0] alu_result_s;
  logic                  alu_zero_s, alu_carry_s, alu_ovf_s;
  logic                  in_ready_s, capture_s, exc_s, is_addsub_s;

  alu_ex_stage_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a_i      (bus.in_a),
    .b_i      (bus.in_b),
    .aluop_i  (bus.in_aluop),
    .result_o (alu_result_s),
    .zero_o   (alu_zero_s),
    .carry_o  (alu_carry_s),
    .ovf_o    (alu_ovf_s)
  );

  assign in_ready_s  = (state_q == ST_EMPTY) || bus.out_ready;
  assign capture_s   = bus.in_valid && in_ready_s && !bus.flush;
  assign is_addsub_s = (bus.in_aluop == 3'(ALU_ADD)) || (bus.in_aluop == 3'(ALU_SUB));
  assign exc_s       = bus.in_trap_en && alu_ovf_s && is_addsub_s;

  // Next state, EX/MEM fields and counters; flush overrides both capture and hold.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    zero_d       = zero_q;
    carry_d      = carry_q;
    exc_d        = exc_q;
    wen_d        = wen_q;
    waddr_d      = waddr_q;
    cnt_issued_d = cnt_issued_q;
    cnt_stall_d  = cnt_stall_q;
    cnt_ovf_d    = cnt_ovf_q;

    case (state_q)
      ST_EMPTY: begin
        if (capture_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (bus.flush) begin
          state_d = ST_EMPTY;
        end else if (capture_s) begin
          state_d = ST_FULL;
        end else if (bus.out_ready) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (capture_s) begin
      result_d     = alu_result_s;
      zero_d       = alu_zero_s;
      carry_d      = alu_carry_s;
      exc_d        = exc_s;
      wen_d        = bus.in_wen && !exc_s;
      waddr_d      = bus.in_waddr;
      cnt_issued_d = cnt_issued_q + CNT_WIDTH'(1);
      if (exc_s) begin
        cnt_ovf_d = cnt_ovf_q + CNT_WIDTH'(1);
      end else begin
        cnt_ovf_d = cnt_ovf_q;
      end
    end else begin
      cnt_issued_d = cnt_issued_q;
    end

    if ((state_q == ST_FULL) && !bus.out_ready && !bus.flush) begin
      cnt_stall_d = cnt_stall_q + CNT_WIDTH'(1);
    end else begin
      cnt_stall_d = cnt_stall_q;
    end
  end

  // Stage register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_EMPTY;
      result_q     <= {DATA_WIDTH{1'b0}};
      zero_q       <= 1'b0;
      carry_q      <= 1'b0;
      exc_q        <= 1'b0;
      wen_q        <= 1'b0;
      waddr_q      <= 5'd0;
      cnt_issued_q <= {CNT_WIDTH{1'b0}};
      cnt_stall_q  <= {CNT_WIDTH{1'b0}};
      cnt_ovf_q    <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      carry_q      <= carry_d;
      exc_q        <= exc_d;
      wen_q        <= wen_d;
      waddr_q      <= waddr_d;
      cnt_issued_q <= cnt_issued_d;
      cnt_stall_q  <= cnt_stall_d;
      cnt_ovf_q    <= cnt_ovf_d;
    end
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.out_valid  = (state_q == ST_FULL);
  assign bus.out_result = result_q;
  assign bus.out_zero   = zero_q;
  assign bus.out_carry  = carry_q;
  assign bus.out_exc    = exc_q;
  assign bus.out_wen    = wen_q;
  assign bus.out_waddr  = waddr_q;
  assign bus.cnt_issued = cnt_issued_q;
  assign bus.cnt_stall  = cnt_stall_q;
  assign bus.cnt_ovf    = cnt_ovf_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: hand-computed vectors checked with immediate assertions.
module tb_alu_ex_stage;
  import alu_ex_stage_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_ex_stage_if #(.DATA_WIDTH(32), .CNT_WIDTH(32)) bus ();

  alu_ex_stage #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic trap, input logic [4:0] wa);
    bus.in_valid   = v;
    bus.in_aluop   = op;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_trap_en = trap;
    bus.in_wen     = 1'b1;
    bus.in_waddr   = wa;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_result", bus.out_result, 32'd0);
    chk("rst_flags", {bus.out_zero, bus.out_carry, bus.out_exc, bus.out_wen}, 4'b0000);
    chk("rst_waddr", bus.out_waddr, 5'd0);
    chk("rst_cnts", {bus.cnt_issued, bus.cnt_stall, bus.cnt_ovf}, 96'd0);
    chk("rst_in_ready", bus.in_ready, 1'b1);

    drive(1'b1, 3'b010, 32'd3, 32'd4, 1'b1, 5'd5);
    tick();
    drive(1'b0, 3'b010, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("add_valid", bus.out_valid, 1'b1);
    chk("add_result", bus.out_result, 32'd7);
    chk("add_exc_wen", {bus.out_exc, bus.out_wen}, 2'b01);
    chk("add_waddr", bus.out_waddr, 5'd5);
    chk("add_zc", {bus.out_zero, bus.out_carry}, 2'b00);
    chk("add_issued", bus.cnt_issued, 32'd1);

    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1, 1'b1, 5'd6);
    tick();
    chk("ovf_result", bus.out_result, 32'h8000_0000);
    chk("ovf_exc_wen", {bus.out_exc, bus.out_wen}, 2'b10);
    chk("ovf_cnt", bus.cnt_ovf, 32'd1);
    chk("ovf_issued", bus.cnt_issued, 32'd2);

    drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'd1, 1'b0, 5'd6);
    tick();
    chk("addu_exc_wen", {bus.out_exc, bus.out_wen}, 2'b01);
    chk("addu_ovf_cnt", bus.cnt_ovf, 32'd1);

    drive(1'b1, 3'b110, 32'd5, 32'd5, 1'b1, 5'd7);
    tick();
    chk("sub_result", bus.out_result, 32'd0);
    chk("sub_zc", {bus.out_zero, bus.out_carry}, 2'b11);

    drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd8);
    tick();
    chk("slt_result", bus.out_result, 32'd1);

    drive(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 1'b0, 5'd8);
    tick();
    chk("sltu_result", bus.out_result, 32'd0);
    chk("sltu_zero", bus.out_zero, 1'b1);

    drive(1'b1, 3'b011, 32'd0, 32'h0000_1234, 1'b0, 5'd9);
    tick();
    chk("lui_result", bus.out_result, 32'h1234_0000);

    drive(1'b1, 3'b001, 32'h0000_00F0, 32'h0000_000F, 1'b0, 5'd10);
    tick();
    chk("or_result", bus.out_result, 32'h0000_00FF);

    drive(1'b1, 3'b000, 32'h0000_00F0, 32'h0000_003C, 1'b0, 5'd10);
    tick();
    chk("and_result", bus.out_result, 32'h0000_0030);

    drive(1'b1, 3'b101, 32'd4, 32'd1, 1'b0, 5'd11);
    tick();
    chk("sll_result", bus.out_result, 32'h0000_0010);

    drive(1'b1, 3'b110, 32'h8000_0000, 32'd1, 1'b1, 5'd12);
    tick();
    chk("subovf_result", bus.out_result, 32'h7FFF_FFFF);
    chk("subovf_exc_wen", {bus.out_exc, bus.out_wen}, 2'b10);
    chk("subovf_cnts", {bus.cnt_issued, bus.cnt_ovf}, {32'd11, 32'd2});

    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    chk("drain_valid", bus.out_valid, 1'b0);
    chk("drain_hold", bus.out_result, 32'h7FFF_FFFF);

    // Backpressure: three ops offered against a 4-cycle stall.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cnts", {bus.cnt_issued, bus.cnt_stall, bus.cnt_ovf}, 96'd0);
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd1, 32'd1, 1'b0, 5'd1);
    tick();
    drive(1'b1, 3'b010, 32'd2, 32'd2, 1'b0, 5'd2);
    chk("bp_op1", bus.out_result, 32'd2);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold", {bus.out_valid, bus.out_waddr, bus.out_result}, {1'b1, 5'd1, 32'd2});
      chk("bp_in_ready_hold", bus.in_ready, 1'b0);
    end
    chk("bp_stall", bus.cnt_stall, 32'd4);
    chk("bp_issued1", bus.cnt_issued, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    chk("bp_ready_release", bus.in_ready, 1'b1);
    tick();
    chk("bp_op2", {bus.out_valid, bus.out_waddr, bus.out_result}, {1'b1, 5'd2, 32'd4});
    drive(1'b1, 3'b010, 32'd3, 32'd3, 1'b0, 5'd3);
    tick();
    chk("bp_op3", {bus.out_valid, bus.out_waddr, bus.out_result}, {1'b1, 5'd3, 32'd6});
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    chk("bp_empty", bus.out_valid, 1'b0);
    chk("bp_counts", {bus.cnt_issued, bus.cnt_stall}, {32'd3, 32'd4});

    // Flush while FULL with a new op offered.
    bus.out_ready = 1'b0;
    drive(1'b1, 3'b010, 32'd10, 32'd10, 1'b0, 5'd4);
    tick();
    chk("fl_full", {bus.out_valid, bus.out_result}, {1'b1, 32'd20});
    drive(1'b1, 3'b010, 32'd7, 32'd7, 1'b0, 5'd5);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("fl_valid", bus.out_valid, 1'b0);
    chk("fl_counts", {bus.cnt_issued, bus.cnt_stall}, {32'd4, 32'd4});
    chk("fl_result_hold", bus.out_result, 32'd20);

    // Reset during a stall.
    drive(1'b1, 3'b010, 32'd1, 32'd2, 1'b0, 5'd6);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
    chk("rs_stalled", {bus.out_valid, bus.cnt_stall}, {1'b1, 32'd5});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rs_valid", bus.out_valid, 1'b0);
    chk("rs_cnts", {bus.cnt_issued, bus.cnt_stall, bus.cnt_ovf}, 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
